// File: rtl/instr_mem_pipe.sv
// Read-only instruction memory with a valid/ready fetch port, in-order responses
// after READ_LAT cycles, fault flags, flush, and a small output FIFO for backpressure.
module instr_mem_pipe #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 256,
  parameter int              READ_LAT  = 1,
  parameter int              BYTE_ADDR = 1,
  parameter string           INIT_FILE = "",
  parameter logic [XLEN-1:0] NOP_WORD  = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_instr,
  output logic [1:0]      resp_fault
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CAP = READ_LAT + 1;
  localparam int CW  = $clog2(CAP + 1);
  localparam int PW  = $clog2(CAP);

  typedef logic [XLEN-1:0] mem_t [DEPTH];

  function automatic mem_t f_init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = XLEN'(32'hC0DE_0000 + i);
    return m;
  endfunction

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CAP - 1)) ? '0 : p + PW'(1);
  endfunction

  mem_t r_mem = f_init_mem();

  logic [XLEN-1:0] w_index;
  logic            w_mis;
  logic            w_oor;
  logic            w_accept;

  // Range check uses the full-width index so large addresses never alias into the array.
  assign w_index  = (BYTE_ADDR != 0) ? (req_addr >> 2) : req_addr;
  assign w_mis    = (BYTE_ADDR != 0) && (req_addr[1:0] != 2'b00);
  assign w_oor    = (w_index >= XLEN'(DEPTH));
  assign w_accept = req_valid && req_ready;

  logic [XLEN-1:0] r_rd_data;
  always_ff @(posedge clk) begin
    r_rd_data <= r_mem[w_index[AW-1:0]];
  end

  logic            r_s1_valid;
  logic [1:0]      r_s1_fault;
  logic [XLEN-1:0] w_s1_instr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_s1_valid <= 1'b0;
      r_s1_fault <= 2'b00;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_fault <= {w_oor, w_mis};
    end
  end

  assign w_s1_instr = (r_s1_fault != 2'b00) ? NOP_WORD : r_rd_data;

  logic            w_pl_valid;
  logic [XLEN-1:0] w_pl_instr;
  logic [1:0]      w_pl_fault;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic            r_s2_valid;
      logic [XLEN-1:0] r_s2_instr;
      logic [1:0]      r_s2_fault;
      always_ff @(posedge clk) begin
        if (rst || flush) r_s2_valid <= 1'b0;
        else              r_s2_valid <= r_s1_valid;
        r_s2_instr <= w_s1_instr;
        r_s2_fault <= r_s1_fault;
      end
      assign w_pl_valid = r_s2_valid;
      assign w_pl_instr = r_s2_instr;
      assign w_pl_fault = r_s2_fault;
    end else begin : g_lat1
      assign w_pl_valid = r_s1_valid;
      assign w_pl_instr = w_s1_instr;
      assign w_pl_fault = r_s1_fault;
    end
  endgenerate

  logic [XLEN-1:0] r_fifo_instr [2**PW];
  logic [1:0]      r_fifo_fault [2**PW];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_fifo_cnt;
  logic [CW-1:0]   r_count;
  logic            w_fifo_empty;
  logic            w_pop;
  logic            w_fifo_push;
  logic            w_fifo_pop;

  // The pipeline never stalls: when the FIFO is empty its last stage is shown
  // directly, otherwise every landing read is parked behind older entries.
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign resp_valid   = !w_fifo_empty || w_pl_valid;
  assign w_pop        = resp_valid && resp_ready;
  assign w_fifo_pop   = w_pop && !w_fifo_empty;
  assign w_fifo_push  = w_pl_valid && !(w_fifo_empty && w_pop);

  assign resp_instr = !resp_valid ? '0 : (w_fifo_empty ? w_pl_instr : r_fifo_instr[r_rd_ptr]);
  assign resp_fault = !resp_valid ? '0 : (w_fifo_empty ? w_pl_fault : r_fifo_fault[r_rd_ptr]);

  always_ff @(posedge clk) begin
    if (w_fifo_push) begin
      r_fifo_instr[r_wr_ptr] <= w_pl_instr;
      r_fifo_fault[r_wr_ptr] <= w_pl_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_fifo_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_fifo_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_fifo_push, w_fifo_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Occupancy covers both in-flight reads and parked responses, so the FIFO cannot overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign req_ready = !rst && !flush && (r_count < CW'(CAP));

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Self-checking bench for instr_mem_pipe: three parameterisations driven from one
// stimulus set, checked against a queue-based reference model of the fetch protocol.
module tb_instr_mem_pipe;
  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        flush      = 1'b0;
  logic        req_valid  = 1'b0;
  logic        resp_ready = 1'b0;
  logic [31:0] req_addr   = '0;
  int          sel        = 0;
  int          lat        = 1;
  int          bmode      = 1;

  logic        rdy [3];
  logic        vld [3];
  logic [31:0] ins [3];
  logic [1:0]  flt [3];

  always #5 clk = ~clk;

  instr_mem_pipe #(.READ_LAT(1), .BYTE_ADDR(1)) u_lat1 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid && sel == 0), .req_ready(rdy[0]),
    .req_addr(req_addr), .resp_valid(vld[0]), .resp_ready(resp_ready && sel == 0),
    .resp_instr(ins[0]), .resp_fault(flt[0]));
  instr_mem_pipe #(.READ_LAT(2), .BYTE_ADDR(1)) u_lat2 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid && sel == 1), .req_ready(rdy[1]),
    .req_addr(req_addr), .resp_valid(vld[1]), .resp_ready(resp_ready && sel == 1),
    .resp_instr(ins[1]), .resp_fault(flt[1]));
  instr_mem_pipe #(.READ_LAT(1), .BYTE_ADDR(0)) u_word (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid && sel == 2), .req_ready(rdy[2]),
    .req_addr(req_addr), .resp_valid(vld[2]), .resp_ready(resp_ready && sel == 2),
    .resp_instr(ins[2]), .resp_fault(flt[2]));

  // Reference model: queue of accepted-but-unconsumed requests with their request cycle.
  typedef struct { logic [33:0] w; int c; } ent_t;
  ent_t q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic        s_valid, s_ready;
  logic [31:0] s_instr;
  logic [1:0]  s_fault;
  logic        e_valid, e_ready;
  logic [33:0] e_word;
  logic [33:0] p_word  = '0;
  logic        p_stall = 1'b0;

  function automatic logic [33:0] f_expect(input logic [31:0] a, input int bm);
    longint idx = (bm != 0) ? longint'(a >> 2) : longint'(a);
    logic   mis = (bm != 0) && (a[1:0] != 2'b00);
    logic   oor = (idx >= 256);
    if (mis || oor) return {oor, mis, 32'h0000_0013};
    return {2'b00, 32'hC0DE_0000 + 32'(idx)};
  endfunction

  task automatic sample();
    @(negedge clk);
    s_valid = vld[sel];
    s_ready = rdy[sel];
    s_instr = ins[sel];
    s_fault = flt[sel];
    e_ready = !rst && !flush && (q.size() < lat + 1);
    e_valid = (q.size() > 0) && (cyc >= q[0].c + lat);
    e_word  = (q.size() > 0) ? q[0].w : '0;
  endtask

  task automatic commit();
    p_stall = s_valid && !resp_ready && !flush && !rst;
    p_word  = {s_fault, s_instr};
    if (s_valid && resp_ready && !rst)
      $display("txn cyc=%0d dut=%0d instr=%h fault=%b", cyc, sel, s_instr, s_fault);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (e_valid && resp_ready) void'(q.pop_front());
      if (req_valid && e_ready) q.push_back('{f_expect(req_addr, bmode), cyc});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    sample(); commit();
    sample(); commit();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sel = 0; lat = 1; bmode = 1;
    rst = 1'b1; req_valid = 1'b1; req_addr = '0; resp_ready = 1'b1;
    sample(); commit();
    sample(); commit();
    sample();
    if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", s_ready); end
    if (s_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", s_valid); end
    if (s_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got=%h exp=0", s_instr); end
    if (s_fault !== 2'b00) begin n_err++; $display("FAIL reset_fault got=%b exp=00", s_fault); end
    n_vec += 4;
    commit();
    rst = 1'b0; req_valid = 1'b0;
    sample();
    if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got=%b exp=1", s_ready); end
    if (s_valid !== 1'b0) begin n_err++; $display("FAIL reset_release_valid got=%b exp=0", s_valid); end
    n_vec += 2;
    commit();
  endtask

  // Directed in-order list with hand-written expected words; checks the model path too.
  task automatic test_directed(input string tag, input int s, input int bm,
                               input logic [31:0] addrs [4], input logic [33:0] want [4], input int n);
    int sent = 0;
    int got  = 0;
    sel = s; lat = 1; bmode = bm;
    do_reset();
    resp_ready = 1'b1;
    for (int k = 0; k < n + 6; k++) begin
      req_valid = (sent < n);
      req_addr  = addrs[sent % 4];
      sample();
      if (s_ready !== e_ready) begin n_err++; $display("FAIL %s_ready cyc=%0d got=%b exp=%b", tag, cyc, s_ready, e_ready); end
      if (s_valid !== e_valid) begin n_err++; $display("FAIL %s_valid cyc=%0d got=%b exp=%b", tag, cyc, s_valid, e_valid); end
      n_vec += 2;
      if (s_valid && got < n) begin
        n_vec++;
        if ({s_fault, s_instr} !== want[got]) begin
          n_err++; $display("FAIL %s_word #%0d got=%b/%h exp=%b/%h", tag, got, s_fault, s_instr, want[got][33:32], want[got][31:0]);
        end
        got++;
      end
      if (req_valid && e_ready) sent++;
      commit();
    end
    n_vec++;
    if (got !== n) begin n_err++; $display("FAIL %s_count got=%0d exp=%0d", tag, got, n); end
  endtask

  task automatic test_backpressure();
    int sent = 0, acc_stall = 0, pops = 0;
    sel = 1; lat = 2; bmode = 1;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      req_valid  = (sent < 6);
      req_addr   = 32'h20 + 32'(4 * sent);
      resp_ready = (k >= 8);
      sample();
      if (s_ready !== e_ready) begin n_err++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, s_ready, e_ready); end
      if (s_valid !== e_valid) begin n_err++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", cyc, s_valid, e_valid); end
      n_vec += 2;
      if (e_valid) begin
        n_vec++;
        if ({s_fault, s_instr} !== e_word) begin n_err++; $display("FAIL bp_word cyc=%0d got=%h exp=%h", cyc, s_instr, e_word[31:0]); end
      end
      if (k < 8 && req_valid && s_ready) acc_stall++;
      if (s_valid && resp_ready) pops++;
      if (req_valid && e_ready) sent++;
      commit();
      if (sent == 6 && q.size() == 0) break;
    end
    if (acc_stall !== 3) begin n_err++; $display("FAIL bp_accepted_while_stalled got=%0d exp=3", acc_stall); end
    if (pops !== 6) begin n_err++; $display("FAIL bp_responses got=%0d exp=6", pops); end
    n_vec += 2;
  endtask

  task automatic test_random(input int s);
    int sent = 0;
    logic [31:0] a;
    sel = s; lat = (s == 1) ? 2 : 1; bmode = 1;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      req_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        7:       a = {22'($urandom_range(0, 255)), 8'($urandom_range(0, 255))} | 32'h1;
        8:       a = 32'h3F8 + 32'($urandom_range(0, 16));
        9:       a = $urandom;
        default: a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      req_addr   = a;
      resp_ready = ($urandom_range(0, 1) != 0);
      sample();
      if (s_ready !== e_ready) begin n_err++; $display("FAIL rand%0d_ready cyc=%0d got=%b exp=%b", s, cyc, s_ready, e_ready); end
      if (s_valid !== e_valid) begin n_err++; $display("FAIL rand%0d_valid cyc=%0d got=%b exp=%b", s, cyc, s_valid, e_valid); end
      n_vec += 2;
      if (e_valid) begin
        n_vec++;
        if ({s_fault, s_instr} !== e_word) begin
          n_err++; $display("FAIL rand%0d_word cyc=%0d got=%b/%h exp=%b/%h", s, cyc, s_fault, s_instr, e_word[33:32], e_word[31:0]);
        end
      end
      if (p_stall) begin
        n_vec++;
        if ({s_fault, s_instr} !== p_word) begin n_err++; $display("FAIL rand%0d_stable cyc=%0d got=%h exp=%h", s, cyc, s_instr, p_word[31:0]); end
      end
      if (req_valid && e_ready) sent++;
      commit();
      if (sent == 200 && q.size() == 0) break;
    end
    n_vec++;
    if (sent !== 200 || q.size() != 0) begin n_err++; $display("FAIL rand%0d_timeout sent=%0d pending=%0d exp=200/0", s, sent, q.size()); end
  endtask

  task automatic test_flush();
    sel = 1; lat = 2; bmode = 1;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      req_valid  = (k < 3) || (k == 4);
      req_addr   = (k == 4) ? 32'h10 : 32'h40 + 32'(4 * k);
      resp_ready = (k >= 4);
      flush      = (k == 3);
      sample();
      if (s_ready !== e_ready) begin n_err++; $display("FAIL flush_ready cyc=%0d got=%b exp=%b", cyc, s_ready, e_ready); end
      if (s_valid !== e_valid) begin n_err++; $display("FAIL flush_valid cyc=%0d got=%b exp=%b", cyc, s_valid, e_valid); end
      n_vec += 2;
      if (k == 3) begin
        n_vec++;
        if (s_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid got=%b exp=1", s_valid); end
      end
      if (k == 4) begin
        n_vec += 2;
        if (s_valid !== 1'b0) begin n_err++; $display("FAIL flush_post_valid got=%b exp=0", s_valid); end
        if (s_ready !== 1'b1) begin n_err++; $display("FAIL flush_post_ready got=%b exp=1", s_ready); end
      end
      if (k == 6) begin
        n_vec++;
        if ({s_valid, s_fault, s_instr} !== {1'b1, 2'b00, 32'hC0DE_0004}) begin
          n_err++; $display("FAIL flush_redirect got=%b/%b/%h exp=1/00/c0de0004", s_valid, s_fault, s_instr);
        end
      end
      commit();
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_inflight();
    int late = 0;
    sel = 2; lat = 1; bmode = 0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      req_valid  = (k < 2);
      req_addr   = 32'd7 + 32'(k);
      resp_ready = (k >= 3);
      rst        = (k == 2);
      sample();
      if (s_ready !== e_ready) begin n_err++; $display("FAIL rstfly_ready cyc=%0d got=%b exp=%b", cyc, s_ready, e_ready); end
      n_vec++;
      if (k >= 3 && s_valid) late++;
      commit();
    end
    rst = 1'b0;
    n_vec++;
    if (late !== 0) begin n_err++; $display("FAIL rstfly_stale_responses got=%0d exp=0", late); end
  endtask

  initial begin
    logic [31:0] a_basic [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [33:0] w_basic [4] = '{{2'b00, 32'hC0DE_0000}, {2'b00, 32'hC0DE_0001},
                                 {2'b00, 32'hC0DE_0002}, {2'b00, 32'hC0DE_0003}};
    logic [31:0] a_fault [4] = '{32'h3, 32'h400, 32'h401, 32'h3FC};
    logic [33:0] w_fault [4] = '{{2'b01, 32'h13}, {2'b10, 32'h13},
                                 {2'b11, 32'h13}, {2'b00, 32'hC0DE_00FF}};
    logic [31:0] a_word  [4] = '{32'd5, 32'd255, 32'd256, 32'd0};
    logic [33:0] w_word  [4] = '{{2'b00, 32'hC0DE_0005}, {2'b00, 32'hC0DE_00FF},
                                 {2'b10, 32'h13}, {2'b00, 32'hC0DE_0000}};
    test_reset();
    test_directed("basic", 0, 1, a_basic, w_basic, 4);
    test_directed("fault", 0, 1, a_fault, w_fault, 4);
    test_backpressure();
    test_random(0);
    test_random(1);
    test_flush();
    test_directed("word", 2, 0, a_word, w_word, 3);
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
